// File: rtl/mem_check_pkg.sv
// Shared types for the store-sequence checker: FSM states and failure codes.
package mem_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE        = 2'd0,
      FC_WRONG_STORE = 2'd1,
      FC_TIMEOUT     = 2'd2
   } fail_code_t;

   localparam int FAIL_CODE_W = 2;

endpackage

// File: rtl/mem_check_timer.sv
// RUN-cycle timer for mem_write_checker; expired is high on the edge
// where the count of enabled cycles reaches TIMEOUT.
module mem_check_timer #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   // Fires on the TIMEOUT-th enabled edge, so the FSM leaves RUN on that edge.
   assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_write_checker.sv
// Checks that a CPU issues an expected in-order sequence of stores.
// Define MEM_CHECK_TIMEOUT_EN to compile in the RUN cycle timer.
module mem_write_checker
   import mem_check_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int N_EXP        = 2,
   parameter int SCRATCH_ADDR = 80,
   parameter int TIMEOUT      = 1000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        memwrite,
   input  logic [ADDR_W-1:0]           dataadr,
   input  logic [DATA_W-1:0]           writedata,
   input  logic [N_EXP*ADDR_W-1:0]     exp_addr,
   input  logic [N_EXP*DATA_W-1:0]     exp_data,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [1:0]                  fail_code,
   output logic [ADDR_W-1:0]           fail_addr,
   output logic [DATA_W-1:0]           fail_data,
   output logic [$clog2(N_EXP+1)-1:0]  match_cnt
);

   localparam int CNT_W = $clog2(N_EXP + 1);

   if (N_EXP < 1 || N_EXP > 16 || TIMEOUT < 1) begin : g_param_err
      $error("mem_write_checker: N_EXP must be 1..16 and TIMEOUT >= 1");
   end

   state_t             state, state_nxt;
   fail_code_t         code_q, code_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [ADDR_W-1:0]  faddr_nxt;
   logic [DATA_W-1:0]  fdata_nxt;

   logic [ADDR_W-1:0]  cur_addr;
   logic [DATA_W-1:0]  cur_data;
   logic               hit;
   logic               scratch_hit;
   logic               last_entry;
   logic               restart;
   logic               expired;

   always_comb begin
      cur_addr = '0;
      cur_data = '0;
      for (int i = 0; i < N_EXP; i++) begin
         if (match_cnt == CNT_W'(i)) begin
            cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
            cur_data = exp_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign hit         = memwrite && (dataadr == cur_addr) && (writedata == cur_data);
   assign scratch_hit = memwrite && (dataadr == ADDR_W'(SCRATCH_ADDR));
   assign last_entry  = (match_cnt == CNT_W'(N_EXP - 1));
   assign restart     = start && (state != RUN);

`ifdef MEM_CHECK_TIMEOUT_EN
   mem_check_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (restart),
      .en      (state == RUN),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      code_nxt  = code_q;
      cnt_nxt   = match_cnt;
      faddr_nxt = fail_addr;
      fdata_nxt = fail_data;
      case (state)
         IDLE, PASS, FAIL: begin
            if (restart) begin
               state_nxt = RUN;
               code_nxt  = FC_NONE;
               cnt_nxt   = '0;
               faddr_nxt = '0;
               fdata_nxt = '0;
            end
         end
         RUN: begin
            if (hit) begin
               cnt_nxt = match_cnt + 1'b1;
            end
            // A matching store wins over the scratch exemption and over a timeout.
            if (memwrite && !hit && !scratch_hit) begin
               state_nxt = FAIL;
               code_nxt  = FC_WRONG_STORE;
               faddr_nxt = dataadr;
               fdata_nxt = writedata;
            end else if (hit && last_entry) begin
               state_nxt = PASS;
            end else if (expired) begin
               state_nxt = FAIL;
               code_nxt  = FC_TIMEOUT;
               faddr_nxt = '0;
               fdata_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         code_q    <= FC_NONE;
         match_cnt <= '0;
         fail_addr <= '0;
         fail_data <= '0;
      end else begin
         state     <= state_nxt;
         code_q    <= code_nxt;
         match_cnt <= cnt_nxt;
         fail_addr <= faddr_nxt;
         fail_data <= fdata_nxt;
      end
   end

   assign busy      = (state == RUN);
   assign done      = (state == PASS) || (state == FAIL);
   assign pass      = (state == PASS);
   assign fail_code = code_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios on two configurations plus
// randomized store streams against a sequence-level reference model.
module tb_mem_write_checker;

   localparam int T1 = 20;
   localparam int T2 = 30;
   localparam int N2 = 2;
`ifdef MEM_CHECK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        start1 = 1'b0, mw1 = 1'b0;
   logic [31:0] adr1 = '0, wd1 = '0, ea1 = 32'd84, ed1 = 32'd7;
   logic        busy1, done1, pass1;
   logic [1:0]  fc1;
   logic [31:0] fa1, fd1;
   logic [0:0]  mc1;

   logic        start2 = 1'b0, mw2 = 1'b0;
   logic [31:0] adr2 = '0, wd2 = '0;
   logic [63:0] ea2 = '0, ed2 = '0;
   logic        busy2, done2, pass2;
   logic [1:0]  fc2;
   logic [31:0] fa2, fd2;
   logic [1:0]  mc2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_write_checker #(.N_EXP(1), .TIMEOUT(T1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .memwrite(mw1), .dataadr(adr1),
      .writedata(wd1), .exp_addr(ea1), .exp_data(ed1), .busy(busy1), .done(done1),
      .pass(pass1), .fail_code(fc1), .fail_addr(fa1), .fail_data(fd1), .match_cnt(mc1)
   );

   mem_write_checker #(.N_EXP(N2), .TIMEOUT(T2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .memwrite(mw2), .dataadr(adr2),
      .writedata(wd2), .exp_addr(ea2), .exp_data(ed2), .busy(busy2), .done(done2),
      .pass(pass2), .fail_code(fc2), .fail_addr(fa2), .fail_data(fd2), .match_cnt(mc2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start1();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
   endtask

   task automatic pulse_start2();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
   endtask

   task automatic store1(input logic [31:0] a, input logic [31:0] d);
      mw1 = 1'b1; adr1 = a; wd1 = d;
      tick();
      mw1 = 1'b0; adr1 = $urandom; wd1 = $urandom;
   endtask

   task automatic store2(input logic [31:0] a, input logic [31:0] d);
      mw2 = 1'b1; adr2 = a; wd2 = d;
      tick();
      mw2 = 1'b0; adr2 = $urandom; wd2 = $urandom;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy1"}, busy1, 0);
      chk({tag, "_done1"}, done1, 0);
      chk({tag, "_pass1"}, pass1, 0);
      chk({tag, "_fc1"},   fc1,   0);
      chk({tag, "_fa1"},   fa1,   0);
      chk({tag, "_mc1"},   mc1,   0);
      chk({tag, "_busy2"}, busy2, 0);
      chk({tag, "_done2"}, done2, 0);
      chk({tag, "_fc2"},   fc2,   0);
      chk({tag, "_fd2"},   fd2,   0);
      chk({tag, "_mc2"},   mc2,   0);
   endtask

   // Reference model for dut2: 0 idle, 1 running, 2 passed, 3 failed.
   int          m_st = 0, m_cnt = 0, m_code = 0, m_runs = 0;
   logic [31:0] m_fa = '0, m_fd = '0;
   logic [31:0] m_ea [N2];
   logic [31:0] m_ed [N2];

   task automatic model_step(input logic s, input logic mw, input logic [31:0] a,
                             input logic [31:0] d);
      bit tmo;
      if (m_st != 1) begin
         if (s) begin
            m_st = 1; m_cnt = 0; m_code = 0; m_fa = '0; m_fd = '0; m_runs = 0;
         end
         return;
      end
      m_runs++;
      tmo = TMO_EN && (m_runs == T2);
      if (mw && a == m_ea[m_cnt] && d == m_ed[m_cnt]) begin
         m_cnt++;
         if (m_cnt == N2) m_st = 2;
         else if (tmo) begin m_st = 3; m_code = 2; end
      end else if (mw && a == 32'd80) begin
         if (tmo) begin m_st = 3; m_code = 2; end
      end else if (mw) begin
         m_st = 3; m_code = 1; m_fa = a; m_fd = d;
      end else if (tmo) begin
         m_st = 3; m_code = 2;
      end
   endtask

   initial begin
      logic [31:0] pool [4];
      logic        s, mw;
      logic [31:0] a, d;
      int          r;
      pool = '{32'd40, 32'd44, 32'd48, 32'd80};

      // Reset state, then no exit from IDLE without start.
      #12;
      chk_zero("rst");
      rst = 1'b1;
      for (int i = 0; i < 3; i++) store1(32'd84, 32'd7);
      chk("idle_busy1", busy1, 0);
      chk("idle_mc1", mc1, 0);

      // Scratch store ignored, then the expected store passes one cycle later.
      pulse_start1();
      chk("b_busy", busy1, 1);
      store1(32'd80, 32'd3);
      chk("b_scratch_busy", busy1, 1);
      chk("b_scratch_pass", pass1, 0);
      store1(32'd84, 32'd7);
      chk("b_pass", pass1, 1);
      chk("b_done", done1, 1);
      chk("b_mc", mc1, 1);
      chk("b_fc", fc1, 0);
      store1(32'd99, 32'd9);
      chk("b_hold_pass", pass1, 1);
      chk("b_hold_fc", fc1, 0);

      // Wrong data at the expected address.
      pulse_start1();
      store1(32'd84, 32'd6);
      chk("c_fc", fc1, 1);
      chk("c_fa", fa1, 84);
      chk("c_fd", fd1, 6);
      chk("c_pass", pass1, 0);
      chk("c_done", done1, 1);

      // Idle RUN: timeout on the 20th RUN edge, or endless RUN without the timer.
      pulse_start1();
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (TMO_EN) begin
            if (i == 19) chk("e_busy19", busy1, 1);
            if (i == 20) begin
               chk("e_done20", done1, 1);
               chk("e_fc20", fc1, 2);
               chk("e_fa20", fa1, 0);
            end
         end else if (i == 100) begin
            chk("e_busy100", busy1, 1);
            chk("e_fc100", fc1, 0);
         end
      end

      // Wrong store on the timeout edge reports a wrong store.
      if (!TMO_EN) begin
         rst = 1'b0; #1; rst = 1'b1;
      end
      pulse_start1();
      for (int i = 1; i < T1; i++) tick();
      chk("f_busy", busy1, 1);
      store1(32'd88, 32'd5);
      chk("f_fc", fc1, 1);
      chk("f_fa", fa1, 88);

      // Out-of-order stores on the two-entry checker.
      ea2 = {32'd44, 32'd40};
      ed2 = {32'd2, 32'd1};
      pulse_start2();
      store2(32'd44, 32'd2);
      chk("d_fc", fc2, 1);
      chk("d_mc", mc2, 0);
      chk("d_fa", fa2, 44);
      store2(32'd40, 32'd1);
      chk("d_hold_fc", fc2, 1);
      chk("d_hold_mc", mc2, 0);

      // Asynchronous reset mid-RUN, then a clean rerun.
      pulse_start2();
      store2(32'd40, 32'd1);
      chk("g_mc1", mc2, 1);
      chk("g_busy", busy2, 1);
      #2 rst = 1'b0;
      #1;
      chk_zero("g_rst");
      #3 rst = 1'b1;
      tick();
      pulse_start2();
      store2(32'd40, 32'd1);
      store2(32'd44, 32'd2);
      chk("g_pass", pass2, 1);
      chk("g_mc2", mc2, 2);

      // Randomized store streams against the model.
      rst = 1'b0; #1; rst = 1'b1;
      m_st = 0; m_cnt = 0; m_code = 0; m_fa = '0; m_fd = '0; m_runs = 0;
      for (int run = 0; run < 12; run++) begin
         for (int k = 0; k < N2; k++) begin
            m_ea[k] = pool[$urandom_range(0, 3)];
            m_ed[k] = $urandom_range(0, 3);
            ea2[k*32 +: 32] = m_ea[k];
            ed2[k*32 +: 32] = m_ed[k];
         end
         for (int c = 0; c < 45; c++) begin
            s  = (c == 0) || ($urandom_range(0, 39) == 0);
            r  = $urandom_range(0, 9);
            mw = 1'b0;
            a  = $urandom;
            d  = $urandom;
            if (r < 3) begin
               mw = 1'b0;
            end else if (r < 7 && m_st == 1) begin
               mw = 1'b1; a = m_ea[m_cnt]; d = m_ed[m_cnt];
            end else if (r < 8) begin
               mw = 1'b1; a = 32'd80; d = $urandom_range(0, 3);
            end else begin
               mw = 1'b1; a = pool[$urandom_range(0, 3)]; d = $urandom_range(0, 3);
            end
            start2 = s; mw2 = mw; adr2 = a; wd2 = d;
            model_step(s, mw, a, d);
            tick();
            chk("r_busy", busy2, m_st == 1);
            chk("r_done", done2, m_st >= 2);
            chk("r_pass", pass2, m_st == 2);
            chk("r_fc",   fc2,   m_code);
            chk("r_fa",   fa2,   m_fa);
            chk("r_fd",   fd2,   m_fd);
            chk("r_mc",   mc2,   m_cnt);
         end
      end
      start2 = 1'b0;
      mw2 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter ADDR_W, default 32: width of the data-memory address bus.
REQ-002 Parameter DATA_W, default 32: width of the store-data bus.
REQ-003 Parameter N_EXP, default 2, range 1..16: number of expected stores in the required sequence.
REQ-004 Parameter SCRATCH_ADDR, default 80: address whose stores are tolerated and ignored.
REQ-005 Parameter TIMEOUT, default 1000: cycle budget in RUN before a timeout failure.
REQ-006 Ports clk and rst: one clock, clk; reset rst is asynchronous and active-low.
REQ-007 start  in  1: one-cycle pulse that begins a check run.
REQ-008 memwrite  in  1: store strobe from the CPU under test.
REQ-009 dataadr  in  ADDR_W: store address, valid when memwrite=1.
REQ-010 writedata  in  DATA_W: store data, valid when memwrite=1.
REQ-011 exp_addr  in  N_EXP*ADDR_W: expected addresses; entry i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 exp_data  in  N_EXP*DATA_W: expected data, packed the same way as exp_addr.
REQ-013 busy  out  1: high while in RUN.
REQ-014 done  out  1: high in PASS or FAIL.
REQ-015 pass  out  1: high in PASS only.
REQ-016 fail_code  out  2: 0 none, 1 wrong store, 2 timeout.
REQ-017 fail_addr / fail_data  out  ADDR_W / DATA_W: capture of the offending store.
REQ-018 match_cnt  out  clog2(N_EXP+1): number of expected stores matched so far.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN, PASS and FAIL, and all inputs SHALL be sampled on the rising edge of clk.
- IDLE->RUN: on start; match_cnt and the timer clear.
- PASS and FAIL: exit only on start, to RUN with counters cleared, or on reset.
- start while in RUN: ignored.
REQ-020 In RUN, a store with memwrite=1, dataadr==exp_addr[match_cnt] and writedata==exp_data[match_cnt] SHALL increment match_cnt.
REQ-021 In RUN, a store to SCRATCH_ADDR that does not match the current expected entry SHALL be ignored.
- A match takes precedence when the expected address equals SCRATCH_ADDR.
REQ-022 In RUN, any other store SHALL move the FSM to FAIL with fail_code=1 and capture dataadr/writedata into fail_addr/fail_data.
REQ-023 When match_cnt reaches N_EXP the FSM SHALL enter PASS.
- done and pass rise the cycle after the final matching store (latency 1).
REQ-024 In PASS/FAIL, memwrite SHALL have no effect and all outputs SHALL hold.
REQ-025 A wrong store on the same edge as the timer reaching TIMEOUT SHALL report fail_code=1 (store error has priority).
REQ-026 When memwrite=0, dataadr and writedata SHALL be don't-care and SHALL never cause a transition.

Reset
REQ-027 While rst=0, the state SHALL be IDLE and all outputs SHALL be zero, asynchronously.
- Applies also when rst asserts mid-RUN; the partial run is discarded.
REQ-028 After rst deasserts, the block SHALL leave IDLE only on start.

Configuration
REQ-029 Macro MEM_CHECK_TIMEOUT_EN, when defined, SHALL compile in the RUN cycle timer.
- Timer counts every RUN cycle.
- On reaching TIMEOUT: FAIL with fail_code=2; fail_addr/fail_data are zero.
REQ-030 Without MEM_CHECK_TIMEOUT_EN, no timer logic SHALL exist, RUN SHALL persist indefinitely and fail_code SHALL never be 2.

Structure
REQ-031 Package mem_check_pkg SHALL hold the FSM state enum and the fail_code enum (NONE, WRONG_STORE, TIMEOUT).
REQ-032 The timer SHALL be a sub-module, mem_check_timer, instantiated only under MEM_CHECK_TIMEOUT_EN.
- Ports: clk, rst, clear, en, expired.

Verification
REQ-033 The bench SHALL cover the following directed scenarios (defaults, timeout enabled unless stated):
- exp={(84,7)}, N_EXP=1; start, store (80,3), then store (84,7) -> pass=1 one cycle after the (84,7) store, match_cnt=1, fail_code=0.
- exp={(84,7)}; start, store (84,6) -> fail_code=1, fail_addr=84, fail_data=6, pass=0.
- N_EXP=2, exp={(40,1),(44,2)}; stores (44,2) then (40,1) -> FAIL at the first store (out of order), match_cnt=0.
- TIMEOUT=20, no stores after start -> FAIL with fail_code=2 on cycle 20 of RUN; same stimulus without the macro -> busy stays 1 for 100 cycles.
- rst pulled low mid-RUN after one match -> all outputs 0 immediately; a new start with the same exp passes.
- Wrong store on the exact timeout edge -> fail_code=1.
